// File: rtl/gradient_pkg.sv
// Shared state encoding and arithmetic helpers for the gradient-generator sequencer.
package gradient_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_PRIME   = 3'd1;
    localparam state_t ST_SETTLE  = 3'd2;
    localparam state_t ST_COLLECT = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    // Ratio must pin at full scale rather than wrap back to a lean mix.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_val
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/gradient_pwm.sv
// Free-running PWM counter with complementary inlet A/B compare outputs.
module gradient_pwm #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty_a,
    output logic              pwm_a,
    output logic              pwm_b
);

    logic [DUTY_W-1:0] cnt_q;
    logic [DUTY_W-1:0] cnt_d;
    logic [DUTY_W-1:0] duty_b;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Inlet B gets whatever inlet A does not: (2^DUTY_W - 1) - duty_a.
    assign duty_b = ~duty_a;
    assign pwm_a  = (cnt_q < duty_a);
    assign pwm_b  = (cnt_q < duty_b);

endmodule

// File: rtl/gradient_sequencer.sv
// Steps a two-inlet gradient chip through a mixing-ratio profile and collects
// each outlet in turn through a sample request/acknowledge handshake.
module gradient_sequencer
    import gradient_pkg::*;
#(
    parameter int NUM_OUT = 8,
    parameter int DUTY_W  = 8,
    parameter int CNT_W   = 16,
    parameter int STEP_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CNT_W-1:0]           cfg_prime_cycles,
    input  logic [CNT_W-1:0]           cfg_dwell_cycles,
    input  logic [STEP_W-1:0]          cfg_num_steps,
    input  logic [DUTY_W-1:0]          cfg_ratio_init,
    input  logic [DUTY_W-1:0]          cfg_ratio_inc,
    input  logic                       sample_ack,
    output logic                       valve_a,
    output logic                       valve_b,
    output logic                       valve_waste,
    output logic [NUM_OUT-1:0]         valve_out,
    output logic                       sample_req,
    output logic [$clog2(NUM_OUT)-1:0] sample_idx,
    output logic [STEP_W-1:0]          step_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int SIDX_W = $clog2(NUM_OUT);
    localparam logic [SIDX_W-1:0] LAST_IDX = SIDX_W'(NUM_OUT - 1);

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    timer_q,     timer_d;
    logic [DUTY_W-1:0]   ratio_q,     ratio_d;
    logic [STEP_W-1:0]   step_q,      step_d;
    logic [SIDX_W-1:0]   sidx_q,      sidx_d;
    logic                req_q,       req_d;
    logic [CNT_W-1:0]    dwell_q,     dwell_d;
    logic [STEP_W-1:0]   steps_q,     steps_d;
    logic [DUTY_W-1:0]   inc_q,       inc_d;
    logic                valve_a_q,   valve_a_d;
    logic                valve_b_q,   valve_b_d;
    logic                waste_q,     waste_d;
    logic [NUM_OUT-1:0]  vout_q,      vout_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                pwm_a;
    logic                pwm_b;

    // Timers count down to zero, so a programmed length of 0 still yields one cycle.
    function automatic logic [CNT_W-1:0] timer_load(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : (n - 1'b1);
    endfunction

    gradient_pwm #(
        .DUTY_W (DUTY_W)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .duty_a (ratio_d),
        .pwm_a  (pwm_a),
        .pwm_b  (pwm_b)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ratio_d = ratio_q;
        step_d  = step_q;
        sidx_d  = sidx_q;
        req_d   = req_q;
        dwell_d = dwell_q;
        steps_d = steps_q;
        inc_d   = inc_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dwell_d = cfg_dwell_cycles;
                    steps_d = cfg_num_steps;
                    inc_d   = cfg_ratio_inc;
                    ratio_d = cfg_ratio_init;
                    step_d  = '0;
                    sidx_d  = '0;
                    if (cfg_num_steps == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PRIME;
                        timer_d = timer_load(cfg_prime_cycles);
                    end
                end
            end

            ST_PRIME: begin
                if (timer_q == '0) begin
                    state_d = ST_SETTLE;
                    timer_d = timer_load(dwell_q);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_COLLECT;
                    sidx_d  = '0;
                    req_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            // A dropped request re-arms after exactly one gap cycle; a held ack cannot double-complete.
            ST_COLLECT: begin
                if (req_q) begin
                    if (sample_ack) begin
                        req_d = 1'b0;
                        if (sidx_q != LAST_IDX) begin
                            sidx_d = sidx_q + 1'b1;
                        end else if (step_q == (steps_q - STEP_W'(1))) begin
                            state_d = ST_DONE;
                            sidx_d  = '0;
                        end else begin
                            state_d = ST_SETTLE;
                            sidx_d  = '0;
                            step_d  = step_q + 1'b1;
                            ratio_d = DUTY_W'(sat_add(32'(ratio_q), 32'(inc_q),
                                                      32'({DUTY_W{1'b1}})));
                            timer_d = timer_load(dwell_q);
                        end
                    end
                end else begin
                    req_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            sidx_d  = '0;
        end
    end

    // Outputs are decoded from the next state so each lands in a flop.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        waste_d   = (state_d == ST_PRIME) || (state_d == ST_SETTLE);
        valve_a_d = 1'b0;
        valve_b_d = 1'b0;
        vout_d    = '0;
        if (state_d == ST_PRIME) begin
            valve_a_d = 1'b1;
            valve_b_d = 1'b1;
        end else if ((state_d == ST_SETTLE) || (state_d == ST_COLLECT)) begin
            valve_a_d = pwm_a;
            valve_b_d = pwm_b;
        end
        if (state_d == ST_COLLECT) begin
            vout_d = NUM_OUT'(1) << sidx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            ratio_q   <= '0;
            step_q    <= '0;
            sidx_q    <= '0;
            req_q     <= 1'b0;
            dwell_q   <= '0;
            steps_q   <= '0;
            inc_q     <= '0;
            valve_a_q <= 1'b0;
            valve_b_q <= 1'b0;
            waste_q   <= 1'b0;
            vout_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ratio_q   <= ratio_d;
            step_q    <= step_d;
            sidx_q    <= sidx_d;
            req_q     <= req_d;
            dwell_q   <= dwell_d;
            steps_q   <= steps_d;
            inc_q     <= inc_d;
            valve_a_q <= valve_a_d;
            valve_b_q <= valve_b_d;
            waste_q   <= waste_d;
            vout_q    <= vout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign valve_a     = valve_a_q;
    assign valve_b     = valve_b_q;
    assign valve_waste = waste_q;
    assign valve_out   = vout_q;
    assign sample_req  = req_q;
    assign sample_idx  = sidx_q;
    assign step_idx    = step_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_gradient_sequencer.sv
// Directed-vector bench for gradient_sequencer: profile timing, outlet order,
// PWM duty per step, handshake gaps, abort and reset behaviour.
module tb_gradient_sequencer;

    localparam int NUM_OUT = 8;
    localparam int DUTY_W  = 8;
    localparam int CNT_W   = 16;
    localparam int STEP_W  = 8;
    localparam int SIDX_W  = $clog2(NUM_OUT);
    localparam int BUDGET  = 3000;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic [CNT_W-1:0]    cfg_prime_cycles;
    logic [CNT_W-1:0]    cfg_dwell_cycles;
    logic [STEP_W-1:0]   cfg_num_steps;
    logic [DUTY_W-1:0]   cfg_ratio_init;
    logic [DUTY_W-1:0]   cfg_ratio_inc;
    logic                sample_ack;
    logic                valve_a;
    logic                valve_b;
    logic                valve_waste;
    logic [NUM_OUT-1:0]  valve_out;
    logic                sample_req;
    logic [SIDX_W-1:0]   sample_idx;
    logic [STEP_W-1:0]   step_idx;
    logic                busy;
    logic                done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int prime;
        int dwell;
        int steps;
        int init;
        int inc;
        int ack_delay;
        int exp_first_req;
        int exp_prime;
        int exp_settle;
        int exp_outlets;
        int exp_done;
        int exp_d0;
        int exp_d1;
        int exp_d2;
        bit check_prime;
        bit check_duty;
    } vec_t;

    gradient_sequencer #(
        .NUM_OUT (NUM_OUT),
        .DUTY_W  (DUTY_W),
        .CNT_W   (CNT_W),
        .STEP_W  (STEP_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_prime_cycles (cfg_prime_cycles),
        .cfg_dwell_cycles (cfg_dwell_cycles),
        .cfg_num_steps    (cfg_num_steps),
        .cfg_ratio_init   (cfg_ratio_init),
        .cfg_ratio_inc    (cfg_ratio_inc),
        .sample_ack       (sample_ack),
        .valve_a          (valve_a),
        .valve_b          (valve_b),
        .valve_waste      (valve_waste),
        .valve_out        (valve_out),
        .sample_req       (sample_req),
        .sample_idx       (sample_idx),
        .step_idx         (step_idx),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int prime, int dwell, int steps, int init, int inc,
                                int ack_delay, int first_req, int prime_len, int settle_len,
                                int outlets, int done_cyc, int d0, int d1, int d2,
                                bit chk_prime, bit chk_duty);
        vec_t v;
        v.prime = prime;          v.dwell = dwell;          v.steps = steps;
        v.init = init;            v.inc = inc;              v.ack_delay = ack_delay;
        v.exp_first_req = first_req;
        v.exp_prime = prime_len;  v.exp_settle = settle_len;
        v.exp_outlets = outlets;  v.exp_done = done_cyc;
        v.exp_d0 = d0;            v.exp_d1 = d1;            v.exp_d2 = d2;
        v.check_prime = chk_prime;
        v.check_duty = chk_duty;
        return v;
    endfunction

    function automatic int exp_duty(vec_t v, int s);
        if (s == 0) return v.exp_d0;
        if (s == 1) return v.exp_d1;
        return v.exp_d2;
    endfunction

    function automatic int outputs_active();
        return int'(valve_a | valve_b | valve_waste | (|valve_out) | sample_req |
                    (|sample_idx) | (|step_idx) | busy | done);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Loads the config, pulses start for one edge, then scrambles the config
    // so that anything not latched at start shows up in the run.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        cfg_prime_cycles = CNT_W'(v.prime);
        cfg_dwell_cycles = CNT_W'(v.dwell);
        cfg_num_steps    = STEP_W'(v.steps);
        cfg_ratio_init   = DUTY_W'(v.init);
        cfg_ratio_inc    = DUTY_W'(v.inc);
        start            = 1'b1;
        @(negedge clk);
        start            = 1'b0;
        cfg_prime_cycles = 16'd9;
        cfg_dwell_cycles = 16'd3;
        cfg_num_steps    = 8'd5;
        cfg_ratio_init   = 8'd17;
        cfg_ratio_inc    = 8'd1;
    endtask

    task automatic run_vector(input int id, input vec_t v);
        int cyc, first_req, prime_a, rises, done_cnt, done_cyc, seq_errs, width_errs;
        int busy_after, activity, req_len, gap_len, age, sum_a, sum_b, post_done, slot, s;
        int hist_a[256];
        int hist_b[256];
        int meas_a[3];
        int meas_b[3];
        logic prev_req;
        string tag;

        for (int i = 0; i < 256; i++) begin
            hist_a[i] = 0;
            hist_b[i] = 0;
        end
        for (int i = 0; i < 3; i++) begin
            meas_a[i] = -1;
            meas_b[i] = -1;
        end
        first_req = -1; prime_a = 0; rises = 0; done_cnt = 0; done_cyc = -1;
        seq_errs = 0; width_errs = 0; busy_after = 0; activity = 0;
        req_len = 0; gap_len = 0; age = 0; sum_a = 0; sum_b = 0; post_done = 0;
        prev_req = 1'b0;
        tag = $sformatf("v%0d", id);

        applyStimulus(v);
        cyc = 1;
        while (cyc <= BUDGET && post_done < 3) begin
            slot = cyc % 256;
            sum_a = sum_a + int'(valve_a) - hist_a[slot];
            sum_b = sum_b + int'(valve_b) - hist_b[slot];
            hist_a[slot] = int'(valve_a);
            hist_b[slot] = int'(valve_b);

            if (first_req < 0 && valve_a) prime_a++;
            if (valve_a || valve_b || valve_waste || valve_out != '0 || sample_req) activity++;

            if (sample_req && !prev_req) begin
                if (first_req < 0) first_req = cyc;
                if (int'(sample_idx) != rises % NUM_OUT) seq_errs++;
                if (int'(step_idx) != rises / NUM_OUT) seq_errs++;
                if (rises % NUM_OUT != 0 && gap_len != 1) width_errs++;
                if (rises % NUM_OUT == 0 && rises / NUM_OUT < 3) begin
                    meas_a[rises / NUM_OUT] = sum_a;
                    meas_b[rises / NUM_OUT] = sum_b;
                end
                rises++;
            end
            if (sample_req) begin
                req_len++;
                gap_len = 0;
                if (valve_out != (NUM_OUT'(1) << sample_idx) || valve_waste) seq_errs++;
            end else begin
                if (prev_req && req_len != v.ack_delay + 1) width_errs++;
                req_len = 0;
                gap_len++;
            end
            prev_req = sample_req;

            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (!busy) seq_errs++;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1 && busy) busy_after = 1;
            if (done_cnt > 0) post_done++;

            if (v.ack_delay == 0) begin
                sample_ack = 1'b1;
            end else begin
                age = sample_req ? age + 1 : 0;
                sample_ack = (age > v.ack_delay);
            end

            @(negedge clk);
            cyc++;
        end
        sample_ack = 1'b0;

        checkOutput({tag, "_first_req"}, first_req, v.exp_first_req);
        checkOutput({tag, "_outlets"}, rises, v.exp_outlets);
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
        checkOutput({tag, "_done_cycle"}, done_cyc, v.exp_done);
        checkOutput({tag, "_outlet_seq_errs"}, seq_errs, 0);
        checkOutput({tag, "_req_gap_errs"}, width_errs, 0);
        checkOutput({tag, "_busy_after_done"}, busy_after, 0);
        if (v.check_prime) begin
            checkOutput({tag, "_prime_len"}, prime_a, v.exp_prime);
            checkOutput({tag, "_settle_len"}, first_req - 1 - prime_a, v.exp_settle);
        end
        if (v.check_duty) begin
            for (s = 0; s < v.steps && s < 3; s++) begin
                checkOutput($sformatf("%s_duty_a_step%0d", tag, s), meas_a[s], exp_duty(v, s));
                checkOutput($sformatf("%s_duty_b_step%0d", tag, s), meas_b[s], 255 - exp_duty(v, s));
            end
        end
        if (v.steps == 0) begin
            checkOutput({tag, "_valve_activity"}, activity, 0);
        end
    endtask

    initial begin
        vec_t vecs[7];
        int active_cnt, done_seen, busy_seen, found, guard;

        vecs[0] = mk(4, 10,  2, 64,  64,  2, 15,  0, 0,  16, 87,  0,   0,   0,   1'b0, 1'b0);
        vecs[1] = mk(4, 300, 2, 64,  64,  2, 305, 0, 0,  16, 667, 64,  128, 0,   1'b0, 1'b1);
        vecs[2] = mk(1, 300, 3, 200, 100, 2, 302, 0, 0,  24, 995, 200, 255, 255, 1'b0, 1'b1);
        vecs[3] = mk(2, 5,   1, 0,   0,   0, 8,   2, 5,  8,  23,  0,   0,   0,   1'b1, 1'b0);
        vecs[4] = mk(0, 0,   1, 0,   10,  1, 3,   1, 1,  8,  26,  0,   0,   0,   1'b1, 1'b0);
        vecs[5] = mk(4, 4,   0, 50,  0,   2, -1,  0, 0,  0,  1,   0,   0,   0,   1'b0, 1'b0);
        vecs[6] = mk(4, 10,  1, 0,   64,  2, 15,  4, 10, 8,  46,  0,   0,   0,   1'b1, 1'b0);

        rst = 1'b1; start = 1'b1; abort = 1'b0; sample_ack = 1'b0;
        cfg_prime_cycles = 16'd4; cfg_dwell_cycles = 16'd10; cfg_num_steps = 8'd1;
        cfg_ratio_init = 8'd64; cfg_ratio_inc = 8'd64;

        // Reset held with start asserted, then 20 idle cycles.
        active_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            active_cnt += outputs_active();
        end
        checkOutput("reset_outputs_active", active_cnt, 0);
        rst = 1'b0;
        start = 1'b0;
        active_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            active_cnt += outputs_active();
        end
        checkOutput("idle_outputs_active", active_cnt, 0);

        // Abort while outlet 3 is being sampled, with ack held high.
        cfg_prime_cycles = 16'd1; cfg_dwell_cycles = 16'd2; cfg_num_steps = 8'd2;
        cfg_ratio_init = 8'd0; cfg_ratio_inc = 8'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sample_ack = 1'b1;
        found = 0;
        guard = 0;
        while (!found && guard < 200) begin
            if (sample_req && sample_idx == SIDX_W'(3)) found = 1;
            else begin
                @(negedge clk);
                guard++;
            end
        end
        checkOutput("abort_reached_idx3", found, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sample_ack = 1'b0;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_valve_out", int'(valve_out), 0);
        checkOutput("abort_sample_req", int'(sample_req), 0);
        checkOutput("abort_inlets_waste", int'({valve_a, valve_b, valve_waste}), 0);
        done_seen = int'(done);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            done_seen += int'(done);
            busy_seen += int'(busy);
        end
        checkOutput("abort_done_pulses", done_seen, 0);
        checkOutput("abort_stays_idle", busy_seen, 0);

        // start and abort together in IDLE: abort wins.
        cfg_num_steps = 8'd1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        busy_seen = int'(busy);
        repeat (10) begin
            @(negedge clk);
            busy_seen += int'(busy);
        end
        checkOutput("start_abort_busy", busy_seen, 0);

        // Synchronous reset in the middle of a run.
        cfg_prime_cycles = 16'd2; cfg_dwell_cycles = 16'd2; cfg_num_steps = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sample_ack = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midrun_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrun_rst_outputs_active", outputs_active(), 0);
        active_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            active_cnt += outputs_active();
        end
        checkOutput("midrun_rst_idle_active", active_cnt, 0);

        for (int i = 0; i < 7; i++) begin
            run_vector(i, vecs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gradient_sequencer.md
Name: gradient_sequencer

Overview:
- Clocked controller for a two-inlet, NUM_OUT-outlet serpentine gradient-generator chip.
- Drives the two inlet valves with complementary PWM to set the inlet mixing ratio, and steps that ratio through a programmed profile.
- After each settle period, collects every outlet in turn using a sample request/acknowledge handshake.
- Sits between the chip's control-layer valve drivers and the host/sampler logic.

Parameters:
NUM_OUT, 8, number of gradient outlets (≥2)
DUTY_W, 8, PWM resolution; period = 2^DUTY_W cycles
CNT_W, 16, width of prime/dwell timers
STEP_W, 8, width of profile step counter

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  begin a profile run (ignored unless IDLE)
abort  in  1  terminate run immediately
cfg_prime_cycles  in  CNT_W  prime duration
cfg_dwell_cycles  in  CNT_W  settle duration per step
cfg_num_steps  in  STEP_W  profile steps
cfg_ratio_init  in  DUTY_W  inlet-A duty at step 0
cfg_ratio_inc  in  DUTY_W  duty increment per step
sample_ack  in  1  sampler done with current outlet
valve_a  out  1  inlet-A valve open
valve_b  out  1  inlet-B valve open
valve_waste  out  1  waste valve open
valve_out  out  NUM_OUT  outlet collect valves, one-hot or zero
sample_req  out  1  outlet open, sample requested
sample_idx  out  $clog2(NUM_OUT)  outlet being sampled
step_idx  out  STEP_W  current profile step
busy  out  1  run in progress
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs 0; state IDLE; PWM counter 0.
- All outputs are registered.
- Config latched on the accepted start; config changes mid-run have no effect.
- PWM: free-running counter pwm_cnt, DUTY_W bits, wraps.
  - duty_a = current ratio; duty_b = (2^DUTY_W − 1) − ratio.
  - In SETTLE and COLLECT: valve_a = (pwm_cnt < duty_a), valve_b = (pwm_cnt < duty_b).
- Ratio update: after the last outlet of a step, ratio += cfg_ratio_inc, saturating at 2^DUTY_W − 1; it never wraps.
- States:
  - IDLE: busy=0, all valves closed.
    - start with cfg_num_steps=0 → DONE.
    - start with cfg_num_steps>0 → PRIME; load ratio=cfg_ratio_init, step_idx=0.
  - PRIME: valve_a=valve_b=valve_waste=1 for max(cfg_prime_cycles,1) cycles → SETTLE.
  - SETTLE: PWM inlets, valve_waste=1, valve_out=0, for max(cfg_dwell_cycles,1) cycles → COLLECT with sample_idx=0.
  - COLLECT: valve_waste=0; valve_out=one-hot(sample_idx); sample_req=1; inlets keep PWM.
    - The cycle sample_ack is seen with sample_req=1, the outlet is done and sample_req deasserts the next cycle.
    - If more outlets remain: sample_idx+1, sample_req reasserts after one gap cycle.
    - After outlet NUM_OUT−1: if step_idx=cfg_num_steps−1 → DONE; else step_idx+1, ratio updated, → SETTLE.
  - DONE: done=1 for one cycle, valves closed → IDLE.
- Handshake:
  - sample_ack while sample_req=0 is ignored.
  - sample_ack held high completes at most one outlet per request.
- Timing: busy=1 from the cycle after the accepted start until DONE is left.
- abort: has priority over every transition. Next cycle the block is in IDLE with all valves closed, sample_req=0 and no done pulse.
- Simultaneous start+abort in IDLE: abort wins; the block stays IDLE.
- rst mid-run: same result as a reset from power-up.

Decomposition:
- Package gradient_pkg: state enum (IDLE, PRIME, SETTLE, COLLECT, DONE) and a saturating-add function.
- Sub-module gradient_pwm (DUTY_W): free-running counter plus the complementary A/B compare outputs.

Test Plan:
1. Reset, then idle 20 cycles → all outputs 0; start ignored while rst is high.
2. Default params; prime=4, dwell=10, steps=2, init=64, inc=64; ack 2 cycles after each req.
   - PRIME lasts 4 cycles.
   - Step 0: valve_a high 64 of every 256 cycles, valve_b high 191 of 256.
   - 8 outlets sampled per step, sample_idx 0..7; then step_idx=1, duty_a=128.
   - A single done pulse at the end.
3. init=200, inc=100, steps=3 → duty_a sequence 200, 255, 255 (saturation, no wrap).
4. Hold sample_ack high continuously → each outlet opens exactly once, with a one-cycle sample_req gap between outlets.
5. abort asserted during COLLECT at sample_idx=3 → next cycle IDLE, valve_out=0, busy=0, done never pulses.
6. cfg_num_steps=0, then prime=0 / dwell=0 with steps=1:
   - steps=0 → done within 2 cycles of start, no valve activity.
   - prime=0 / dwell=0 → PRIME and SETTLE each last exactly 1 cycle.
